// File: rtl/uart_pkg.sv
// Shared types for the parametrised UART transmitter: parity modes, FSM states
// and the idle line level.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_ODD  = 2'd1,
        PAR_EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } tx_state_e;

    localparam logic IDLE_LINE = 1'b1;

    // Parity bit from the XOR of the payload; odd mode inverts it.
    function automatic logic parity_bit(input logic data_xor, input parity_e mode);
        return data_xor ^ (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous TX FIFO with registered full/empty/count. Pointers carry one
// extra MSB so full and empty are told apart when the indices match.
module uart_tx_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [DATA_W-1:0]             data_i,
    input  logic                          pop_i,
    output logic [DATA_W-1:0]             data_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH):0]        count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wptr_q, wptr_d;
    logic [PW-1:0]     rptr_q, rptr_d;
    logic [PW-1:0]     count_q;
    logic              full_q, empty_q;
    logic              do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Next pointer values.
    always_comb begin
        wptr_d = wptr_q + PW'(do_push);
        rptr_d = rptr_q + PW'(do_pop);
    end

    // Storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wptr_q[AW-1:0]] <= data_i;
        end
    end

    // Pointers and registered status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= wptr_d - rptr_d;
            full_q  <= (wptr_d[AW] != rptr_d[AW]) && (wptr_d[AW-1:0] == rptr_d[AW-1:0]);
            empty_q <= (wptr_d == rptr_d);
        end
    end

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign full_o  = full_q;
    assign empty_o = empty_q;
    assign count_o = count_q;

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised buffered UART transmitter (start, DATA_BITS LSB-first, optional
// parity, STOP_BITS stop bits). Define UART_TX_FIFO_EN for a FIFO_DEPTH-entry
// input FIFO; otherwise a single holding register, freed when its frame ends.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 87,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY_MODE  = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_TX_DV,
    input  logic [DATA_BITS-1:0]          i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic                          o_TX_Overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_TX_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done
);

    localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BAUD_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned STOP_CYC = STOP_BITS * CLKS_PER_BIT;
    localparam int unsigned STOP_W   = $clog2(STOP_CYC);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);
    localparam parity_e     PAR_MODE = parity_e'(2'(PARITY_MODE));

    tx_state_e            state_q;
    logic [BAUD_W-1:0]    baud_q;
    logic [STOP_W-1:0]    stop_q;
    logic [IDX_W-1:0]     idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_q;
    logic                 serial_q, active_q, done_q, ovf_q;

    logic                 avail_c, take_c, ready_c, bit_end_c;
    logic [DATA_BITS-1:0] head_c;
    logic [CNT_W-1:0]     count_c;

`ifdef UART_TX_FIFO_EN
    logic fifo_full, fifo_empty;

    // Input FIFO; the FSM pops the head when a frame starts.
    uart_tx_fifo #(
        .DATA_W (DATA_BITS),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (i_TX_DV),
        .data_i  (i_TX_Byte),
        .pop_i   (take_c),
        .data_o  (head_c),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (count_c)
    );

    assign avail_c = !fifo_empty;
    assign ready_c = !fifo_full;
`else
    logic                 hold_valid_q;
    logic [DATA_BITS-1:0] hold_data_q;

    // Holding register stays occupied until its frame reaches CLEANUP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
        end else if (i_TX_DV && !hold_valid_q) begin
            hold_valid_q <= 1'b1;
            hold_data_q  <= i_TX_Byte;
        end else if (state_q == CLEANUP) begin
            hold_valid_q <= 1'b0;
        end
    end

    assign head_c  = hold_data_q;
    assign avail_c = hold_valid_q && (state_q != CLEANUP);
    assign ready_c = !hold_valid_q;
    assign count_c = CNT_W'(hold_valid_q);
`endif

    assign take_c    = avail_c && ((state_q == IDLE) || (state_q == CLEANUP));
    assign bit_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    // Dropped-write indicator, one cycle after the rejected strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= i_TX_DV && !ready_c;
        end
    end

    // Frame FSM with baud counter, bit index, shift register and line driver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            baud_q   <= '0;
            stop_q   <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            serial_q <= IDLE_LINE;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    serial_q <= IDLE_LINE;
                end
                START: begin
                    if (bit_end_c) begin
                        baud_q   <= '0;
                        idx_q    <= '0;
                        serial_q <= shift_q[0];
                        shift_q  <= shift_q >> 1;
                        state_q  <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (bit_end_c) begin
                        baud_q <= '0;
                        if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                            if (PAR_MODE != PAR_NONE) begin
                                serial_q <= par_q;
                                state_q  <= PARITY;
                            end else begin
                                serial_q <= IDLE_LINE;
                                stop_q   <= '0;
                                state_q  <= STOP;
                            end
                        end else begin
                            idx_q    <= idx_q + IDX_W'(1);
                            serial_q <= shift_q[0];
                            shift_q  <= shift_q >> 1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                PARITY: begin
                    if (bit_end_c) begin
                        baud_q   <= '0;
                        serial_q <= IDLE_LINE;
                        stop_q   <= '0;
                        state_q  <= STOP;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (stop_q == STOP_W'(STOP_CYC - 1)) begin
                        stop_q  <= '0;
                        state_q <= CLEANUP;
                    end else begin
                        stop_q <= stop_q + STOP_W'(1);
                    end
                end
                CLEANUP: begin
                    done_q   <= 1'b1;
                    active_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    serial_q <= IDLE_LINE;
                end
            endcase
            // Starting a frame overrides the IDLE/CLEANUP defaults above.
            if (take_c) begin
                state_q  <= START;
                baud_q   <= '0;
                serial_q <= 1'b0;
                active_q <= 1'b1;
                shift_q  <= head_c;
                par_q    <= parity_bit(^head_c, PAR_MODE);
            end
        end
    end

    assign o_TX_Ready    = ready_c;
    assign o_TX_Overflow = ovf_q;
    assign o_TX_Count    = count_c;
    assign o_TX_Active   = active_q;
    assign o_TX_Serial   = serial_q;
    assign o_TX_Done     = done_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: 8N1, 8E1, 8O1 and 7N2 instances at four
// clocks per bit. The buffering test follows UART_TX_FIFO_EN.
module tb_uart_tx_param;

    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] dv  = '0;
    logic [7:0] byte8 = '0;
    logic [6:0] byte7 = '0;
    logic [1:0] sel = '0;

    logic [3:0] ser_w, done_w, act_w, rdy_w, ovf_w;
    logic [2:0] cnt0, cnt1, cnt2, cnt3;

    int checks = 0;
    int failures = 0;

    wire line = ser_w[sel];
    wire done = done_w[sel];
    wire act  = act_w[sel];

    always #5 clk = ~clk;

    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .rst(rst), .i_TX_DV(dv[0]), .i_TX_Byte(byte8), .o_TX_Ready(rdy_w[0]),
        .o_TX_Overflow(ovf_w[0]), .o_TX_Count(cnt0), .o_TX_Active(act_w[0]),
        .o_TX_Serial(ser_w[0]), .o_TX_Done(done_w[0]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .rst(rst), .i_TX_DV(dv[1]), .i_TX_Byte(byte8), .o_TX_Ready(rdy_w[1]),
        .o_TX_Overflow(ovf_w[1]), .o_TX_Count(cnt1), .o_TX_Active(act_w[1]),
        .o_TX_Serial(ser_w[1]), .o_TX_Done(done_w[1]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u2 (
        .clk(clk), .rst(rst), .i_TX_DV(dv[2]), .i_TX_Byte(byte8), .o_TX_Ready(rdy_w[2]),
        .o_TX_Overflow(ovf_w[2]), .o_TX_Count(cnt2), .o_TX_Active(act_w[2]),
        .o_TX_Serial(ser_w[2]), .o_TX_Done(done_w[2]));
    uart_tx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u3 (
        .clk(clk), .rst(rst), .i_TX_DV(dv[3]), .i_TX_Byte(byte7), .o_TX_Ready(rdy_w[3]),
        .o_TX_Overflow(ovf_w[3]), .o_TX_Count(cnt3), .o_TX_Active(act_w[3]),
        .o_TX_Serial(ser_w[3]), .o_TX_Done(done_w[3]));

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One-cycle write strobe to instance s, starting and ending on a negedge.
    task automatic write_byte(input int s, input logic [7:0] d);
        dv[s] = 1'b1;
        byte8 = d;
        byte7 = d[6:0];
        @(negedge clk);
        dv = '0;
    endtask

    // Capture one frame cycle by cycle from its start bit, then check CLEANUP and the Done pulse.
    task automatic rx_check(input string tag, input logic [15:0] bits, input int nb, input logic act_after);
        logic [63:0] wave, exp;
        logic        act_all;
        int          t;
        wave = '0; exp = '0; act_all = 1'b1; t = 0;
        while (line !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            check_eq({tag, "_start"}, 64'(line), 64'd0);
            return;
        end
        for (int k = 0; k < nb * CPB; k++) begin
            wave[k] = line;
            exp[k]  = bits[k / CPB];
            act_all = act_all & act;
            @(negedge clk);
        end
        check_eq({tag, "_wave"}, wave, exp);
        check_eq({tag, "_active"}, 64'(act_all), 64'd1);
        check_eq({tag, "_cleanup_line"}, 64'(line), 64'd1);
        check_eq({tag, "_cleanup_done"}, 64'(done), 64'd0);
        @(negedge clk);
        check_eq({tag, "_done"}, 64'(done), 64'd1);
        check_eq({tag, "_active_after"}, 64'(act), 64'(act_after));
    endtask

    // Watch n cycles: line must stay high and no Done may pulse.
    task automatic quiet_check(input string tag, input int n);
        logic ok;
        ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (line !== 1'b1 || done !== 1'b0) ok = 1'b0;
        end
        check_eq(tag, 64'(ok), 64'd1);
    endtask

    function automatic logic [15:0] frame8n1(input logic [7:0] d);
        return {6'b0, 1'b1, d, 1'b0};
    endfunction

    initial begin
        logic [2:0] exp_q;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reset state
        check_eq("rst_serial", 64'(ser_w[0]), 64'd1);
        check_eq("rst_ready", 64'(rdy_w[0]), 64'd1);
        check_eq("rst_count", 64'(cnt0), 64'd0);
        check_eq("rst_active", 64'(act_w[0]), 64'd0);
        check_eq("rst_done", 64'(done_w[0]), 64'd0);
        check_eq("rst_ovf", 64'(ovf_w[0]), 64'd0);

        // 8N1 0x55: line bits 0,1,0,1,0,1,0,1,0,1
        sel = 2'd0;
        write_byte(0, 8'h55);
        rx_check("n1_55", 16'h02AA, 10, 1'b0);

        // 8E1 0x07: parity 1
        sel = 2'd1;
        write_byte(1, 8'h07);
        rx_check("e1_07", 16'h060E, 11, 1'b0);

        // 8O1 0x07: parity 0
        sel = 2'd2;
        write_byte(2, 8'h07);
        rx_check("o1_07", 16'h040E, 11, 1'b0);

        // 7N2 0x41: 1,0,0,0,0,0,1 then two stop bits
        sel = 2'd3;
        write_byte(3, 8'h41);
        rx_check("n2_41", 16'h0382, 10, 1'b0);

        sel = 2'd0;
`ifdef UART_TX_FIFO_EN
        // Five writes while busy: four accepted, fifth overflows, then four back-to-back frames
        write_byte(0, 8'h11);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            dv[0] = 1'b1;
            byte8 = 8'hA1 + 8'(i);
            @(negedge clk);
            if (i < 4) begin
                check_eq($sformatf("fifo_count%0d", i), 64'(cnt0), 64'(i + 1));
                check_eq($sformatf("fifo_ready%0d", i), 64'(rdy_w[0]), 64'(i < 3));
                check_eq($sformatf("fifo_ovf%0d", i), 64'(ovf_w[0]), 64'd0);
            end else begin
                check_eq("fifo_ovf_pulse", 64'(ovf_w[0]), 64'd1);
                check_eq("fifo_count_full", 64'(cnt0), 64'd4);
            end
        end
        dv = '0;
        @(negedge clk);
        check_eq("fifo_ovf_clear", 64'(ovf_w[0]), 64'd0);
        begin
            int t;
            t = 0;
            while (done !== 1'b1 && t < 100) begin
                @(negedge clk);
                t++;
            end
            check_eq("fifo_first_done", 64'(done), 64'd1);
            check_eq("fifo_active_b2b", 64'(act), 64'd1);
        end
        for (int i = 0; i < 4; i++) begin
            rx_check($sformatf("fifo_f%0d", i), frame8n1(8'hA1 + 8'(i)), 10, i < 3);
        end
        check_eq("fifo_count_drained", 64'(cnt0), 64'd0);
        quiet_check("fifo_idle_after", 20);
`else
        // Holding register: second write during the frame is dropped, one frame sent
        fork
            rx_check("hold_a3", frame8n1(8'hA3), 10, 1'b0);
            begin
                write_byte(0, 8'hA3);
                check_eq("hold_count", 64'(cnt0), 64'd1);
                check_eq("hold_ready", 64'(rdy_w[0]), 64'd0);
                repeat (4) @(negedge clk);
                write_byte(0, 8'h5C);
                check_eq("hold_ovf_pulse", 64'(ovf_w[0]), 64'd1);
                check_eq("hold_count_busy", 64'(cnt0), 64'd1);
                @(negedge clk);
                check_eq("hold_ovf_clear", 64'(ovf_w[0]), 64'd0);
            end
        join
        quiet_check("hold_single_frame", 60);
        check_eq("hold_count_after", 64'(cnt0), 64'd0);
        check_eq("hold_ready_after", 64'(rdy_w[0]), 64'd1);
`endif

        // Reset in the middle of a data bit with entries queued
        write_byte(0, 8'hB1);
`ifdef UART_TX_FIFO_EN
        write_byte(0, 8'hB2);
        write_byte(0, 8'hB3);
        exp_q = 3'd2;
`else
        exp_q = 3'd1;
`endif
        repeat (10) @(negedge clk);
        check_eq("mid_count", 64'(cnt0), 64'(exp_q));
        check_eq("mid_active", 64'(act_w[0]), 64'd1);
        #1 rst = 1'b1;
        #1;
        check_eq("mid_rst_serial", 64'(ser_w[0]), 64'd1);
        check_eq("mid_rst_count", 64'(cnt0), 64'd0);
        check_eq("mid_rst_active", 64'(act_w[0]), 64'd0);
        check_eq("mid_rst_ready", 64'(rdy_w[0]), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        quiet_check("post_rst_idle", 60);
        check_eq("post_rst_count", 64'(cnt0), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
